dlx_pipe_ctrl: RTL and testbench

DLX_PIPE_CTRL -- requirements
Module: dlx_pipe_ctrl

---
 rtl/dlx_global_pkg.sv | 19 +
 rtl/dlx_pipe_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dlx_pipe_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dlx_global_pkg.sv
// Shared DLX pipeline types: instruction classes and operand forwarding selects.
package dlx_global_pkg;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        BRANCH = 3'd3,
        JUMP   = 3'd4,
        OTHER  = 3'd5
    } opcode_class;

    typedef enum logic [1:0] {
        FWDSEL_REG            = 2'd0,
        FWDSEL_EX_MEM_ALU_OUT = 2'd1,
        FWDSEL_MEM_WB         = 2'd2
    } fwd_select;

endpackage

// File: rtl/dlx_pipe_ctrl.sv
// DLX pipeline control: load-use and D-cache stalls, branch flush, operand
// forwarding select, halt/illegal drain sequencing and optional performance
// counters. Define DLX_PIPE_CTRL_PERF_EN to build the stall/flush counters;
// without it both counter outputs are tied to zero.
module dlx_pipe_ctrl
    import dlx_global_pkg::*;
#(
    parameter int unsigned HALT_DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  opcode_class id_opcode_class,
    input  logic [4:0]  id_ir_rs1,
    input  logic [4:0]  id_ir_rs2,
    input  opcode_class id_ex_opcode_class,
    input  logic [4:0]  id_ex_reg_rd,
    input  logic        id_ex_reg_wen,
    input  logic [4:0]  ex_mem_reg_rd,
    input  logic        ex_mem_reg_wen,
    input  logic [4:0]  mem_wb_reg_rd,
    input  logic        mem_wb_reg_wen,
    input  logic        dc_wait,
    input  logic        id_cond,
    input  logic        id_halt,
    input  logic        id_illegal_instr,
    output logic        stall,
    output logic        id_ex_bubble,
    output logic        if_flush,
    output fwd_select   id_a_fwd_sel,
    output fwd_select   id_b_fwd_sel,
    output logic        halted,
    output logic        illegal_err,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] drain_cnt_q, drain_cnt_d;
    logic        illegal_err_q, illegal_err_d;
    logic        load_use;

    // The ID instruction class does not affect any control decision here.
    logic unused_id_class;
    assign unused_id_class = ^id_opcode_class;

    // Load in EX whose destination is read by the instruction in ID.
    assign load_use = (id_ex_opcode_class == LOAD) && id_ex_reg_wen &&
                      (id_ex_reg_rd != 5'd0) &&
                      ((id_ex_reg_rd == id_ir_rs1) || (id_ex_reg_rd == id_ir_rs2));

    // Next-state and stall/bubble/flush decode.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        illegal_err_d = illegal_err_q;
        stall         = 1'b0;
        id_ex_bubble  = 1'b0;
        if_flush      = 1'b0;
        unique case (state_q)
            // MEM_WAIT evaluates exactly like RUN once dc_wait drops, so a
            // branch held in ID during the miss is flushed without delay.
            RUN, MEM_WAIT: begin
                if (dc_wait) begin
                    stall   = 1'b1;
                    state_d = MEM_WAIT;
                end else begin
                    state_d = RUN;
                    if (load_use) begin
                        stall        = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_halt || id_illegal_instr) begin
                        drain_cnt_d = 16'(HALT_DRAIN_CYCLES);
                        state_d     = DRAIN;
                        if (id_illegal_instr) begin
                            illegal_err_d = 1'b1;
                        end
                    end else if (id_cond) begin
                        if_flush = 1'b1;
                    end
                end
            end
            DRAIN: begin
                stall        = 1'b1;
                id_ex_bubble = 1'b1;
                if (!dc_wait) begin
                    // A zero drain length halts straight away.
                    if (drain_cnt_q <= 16'd1) begin
                        state_d = HALTED;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 16'd1;
                    end
                end
            end
            HALTED: begin
                stall        = 1'b1;
                id_ex_bubble = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            drain_cnt_q   <= 16'd0;
            illegal_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            illegal_err_q <= illegal_err_d;
        end
    end

    assign halted      = (state_q == HALTED);
    assign illegal_err = illegal_err_q;

    function automatic fwd_select fwd_for(input logic [4:0] rs);
        if (ex_mem_reg_wen && (ex_mem_reg_rd != 5'd0) && (ex_mem_reg_rd == rs)) begin
            return FWDSEL_EX_MEM_ALU_OUT;
        end else if (mem_wb_reg_wen && (mem_wb_reg_rd != 5'd0) && (mem_wb_reg_rd == rs)) begin
            return FWDSEL_MEM_WB;
        end else begin
            return FWDSEL_REG;
        end
    endfunction

    // Operand forwarding; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        id_a_fwd_sel = fwd_for(id_ir_rs1);
        id_b_fwd_sel = fwd_for(id_ir_rs2);
    end

`ifdef DLX_PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating stall/flush counters; the halted freeze is not a stall event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (stall && (state_q != HALTED) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (if_flush && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    assign perf_stall_cnt = 16'd0;
    assign perf_flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dlx_pipe_ctrl.sv
// Directed self-checking bench for dlx_pipe_ctrl.
module tb_dlx_pipe_ctrl;
    import dlx_global_pkg::*;

    logic        clk;
    logic        rst;
    opcode_class id_opcode_class;
    logic [4:0]  id_ir_rs1;
    logic [4:0]  id_ir_rs2;
    opcode_class id_ex_opcode_class;
    logic [4:0]  id_ex_reg_rd;
    logic        id_ex_reg_wen;
    logic [4:0]  ex_mem_reg_rd;
    logic        ex_mem_reg_wen;
    logic [4:0]  mem_wb_reg_rd;
    logic        mem_wb_reg_wen;
    logic        dc_wait;
    logic        id_cond;
    logic        id_halt;
    logic        id_illegal_instr;
    logic        stall;
    logic        id_ex_bubble;
    logic        if_flush;
    fwd_select   id_a_fwd_sel;
    fwd_select   id_b_fwd_sel;
    logic        halted;
    logic        illegal_err;
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;

    int total = 0;
    int bad   = 0;

    dlx_pipe_ctrl #(
        .HALT_DRAIN_CYCLES(3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_opcode_class   (id_opcode_class),
        .id_ir_rs1         (id_ir_rs1),
        .id_ir_rs2         (id_ir_rs2),
        .id_ex_opcode_class(id_ex_opcode_class),
        .id_ex_reg_rd      (id_ex_reg_rd),
        .id_ex_reg_wen     (id_ex_reg_wen),
        .ex_mem_reg_rd     (ex_mem_reg_rd),
        .ex_mem_reg_wen    (ex_mem_reg_wen),
        .mem_wb_reg_rd     (mem_wb_reg_rd),
        .mem_wb_reg_wen    (mem_wb_reg_wen),
        .dc_wait           (dc_wait),
        .id_cond           (id_cond),
        .id_halt           (id_halt),
        .id_illegal_instr  (id_illegal_instr),
        .stall             (stall),
        .id_ex_bubble      (id_ex_bubble),
        .if_flush          (if_flush),
        .id_a_fwd_sel      (id_a_fwd_sel),
        .id_b_fwd_sel      (id_b_fwd_sel),
        .halted            (halted),
        .illegal_err       (illegal_err),
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_flush_cnt    (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_opcode_class    = ALU;
        id_ir_rs1          = 5'd0;
        id_ir_rs2          = 5'd0;
        id_ex_opcode_class = ALU;
        id_ex_reg_rd       = 5'd0;
        id_ex_reg_wen      = 1'b0;
        ex_mem_reg_rd      = 5'd0;
        ex_mem_reg_wen     = 1'b0;
        mem_wb_reg_rd      = 5'd0;
        mem_wb_reg_wen     = 1'b0;
        dc_wait            = 1'b0;
        id_cond            = 1'b0;
        id_halt            = 1'b0;
        id_illegal_instr   = 1'b0;
    endtask

    // Advance one clock; inputs are then driven on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        idle();
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_perf_stall", 32'(perf_stall_cnt), 32'd0);
        check("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
        step();
        step();
        rst = 1'b1;

        // Load-use on r5 via rs1, then the load moves down and forwards.
        id_ex_opcode_class = LOAD;
        id_ex_reg_rd       = 5'd5;
        id_ex_reg_wen      = 1'b1;
        id_ir_rs1          = 5'd5;
        id_ir_rs2          = 5'd2;
        #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_bubble", 32'(id_ex_bubble), 32'd1);
        step();
        id_ex_opcode_class = ALU;
        id_ex_reg_wen      = 1'b0;
        ex_mem_reg_rd      = 5'd5;
        ex_mem_reg_wen     = 1'b1;
        #1;
        check("lu_mem_stall", 32'(stall), 32'd0);
        check("lu_mem_bubble", 32'(id_ex_bubble), 32'd0);
        check("lu_mem_fwd_a", 32'(id_a_fwd_sel), 32'(FWDSEL_EX_MEM_ALU_OUT));
        step();
        ex_mem_reg_wen = 1'b0;
        mem_wb_reg_rd  = 5'd5;
        mem_wb_reg_wen = 1'b1;
        #1;
        check("lu_wb_stall", 32'(stall), 32'd0);
        check("lu_wb_fwd_a", 32'(id_a_fwd_sel), 32'(FWDSEL_MEM_WB));
        check("lu_wb_fwd_b", 32'(id_b_fwd_sel), 32'(FWDSEL_REG));
        step();

        // Load-use through rs2; a load to r0 is never a hazard.
        idle();
        id_ex_opcode_class = LOAD;
        id_ex_reg_rd       = 5'd9;
        id_ex_reg_wen      = 1'b1;
        id_ir_rs1          = 5'd3;
        id_ir_rs2          = 5'd9;
        #1;
        check("lu_rs2_stall", 32'(stall), 32'd1);
        step();
        id_ex_reg_rd = 5'd0;
        id_ir_rs1    = 5'd0;
        id_ir_rs2    = 5'd0;
        #1;
        check("lu_r0_stall", 32'(stall), 32'd0);
        step();

        // Forwarding priority and register zero.
        idle();
        ex_mem_reg_rd  = 5'd7;
        ex_mem_reg_wen = 1'b1;
        mem_wb_reg_rd  = 5'd7;
        mem_wb_reg_wen = 1'b1;
        id_ir_rs2      = 5'd7;
        #1;
        check("fwd_both_b", 32'(id_b_fwd_sel), 32'(FWDSEL_EX_MEM_ALU_OUT));
        check("fwd_both_a", 32'(id_a_fwd_sel), 32'(FWDSEL_REG));
        step();
        ex_mem_reg_wen = 1'b0;
        #1;
        check("fwd_wb_b", 32'(id_b_fwd_sel), 32'(FWDSEL_MEM_WB));
        step();
        ex_mem_reg_rd  = 5'd0;
        ex_mem_reg_wen = 1'b1;
        mem_wb_reg_rd  = 5'd0;
        id_ir_rs2      = 5'd0;
        #1;
        check("fwd_r0_b", 32'(id_b_fwd_sel), 32'(FWDSEL_REG));
        step();

        // D-cache wait over a taken branch: flush only once the wait ends.
        idle();
        id_cond = 1'b1;
        dc_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("dcw_stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("dcw_flush%0d", i), 32'(if_flush), 32'd0);
            check($sformatf("dcw_bubble%0d", i), 32'(id_ex_bubble), 32'd0);
            step();
        end
        dc_wait = 1'b0;
        #1;
        check("dcw_end_stall", 32'(stall), 32'd0);
        check("dcw_end_flush", 32'(if_flush), 32'd1);
        step();
        id_cond = 1'b0;
        #1;
        check("dcw_after_flush", 32'(if_flush), 32'd0);
        step();

        // Halt with a cache wait in the second drain cycle.
        id_halt = 1'b1;
        id_cond = 1'b1;
        #1;
        check("halt_issue_stall", 32'(stall), 32'd0);
        check("halt_over_cond", 32'(if_flush), 32'd0);
        step();
        idle();
        for (int i = 0; i < 4; i++) begin
            dc_wait = (i == 1);
            #1;
            check($sformatf("drain_stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("drain_bubble%0d", i), 32'(id_ex_bubble), 32'd1);
            check($sformatf("drain_halted%0d", i), 32'(halted), 32'd0);
            step();
        end
        dc_wait          = 1'b0;
        id_cond          = 1'b1;
        id_illegal_instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("hlt_halted%0d", i), 32'(halted), 32'd1);
            check($sformatf("hlt_stall%0d", i), 32'(stall), 32'd1);
            check($sformatf("hlt_flush%0d", i), 32'(if_flush), 32'd0);
            step();
        end
        check("hlt_no_illegal", 32'(illegal_err), 32'd0);
        idle();
        rst = 1'b0;
        #1;
        check("hlt_rst_halted", 32'(halted), 32'd0);
        step();
        rst = 1'b1;

        // Illegal instruction: sticky flag, then halt after the drain.
        id_illegal_instr = 1'b1;
        #1;
        check("ill_issue_stall", 32'(stall), 32'd0);
        step();
        idle();
        #1;
        check("ill_err_set", 32'(illegal_err), 32'd1);
        check("ill_not_halted", 32'(halted), 32'd0);
        step();
        step();
        step();
        #1;
        check("ill_halted", 32'(halted), 32'd1);
        check("ill_err_held", 32'(illegal_err), 32'd1);
        do_reset();

        // Reset in the middle of the drain abandons it immediately.
        id_illegal_instr = 1'b1;
        step();
        idle();
        step();
        rst = 1'b0;
        #1;
        check("ill_rst_err", 32'(illegal_err), 32'd0);
        check("ill_rst_halted", 32'(halted), 32'd0);
        check("ill_rst_stall", 32'(stall), 32'd0);
        step();
        rst = 1'b1;
        #1;
        check("ill_post_stall", 32'(stall), 32'd0);
        step();

        // Reset while waiting on the cache returns to RUN.
        dc_wait = 1'b1;
        step();
        rst     = 1'b0;
        dc_wait = 1'b0;
        step();
        rst     = 1'b1;
        id_cond = 1'b1;
        #1;
        check("mw_rst_stall", 32'(stall), 32'd0);
        check("mw_rst_flush", 32'(if_flush), 32'd1);
        step();
        idle();

        // Performance counters.
`ifdef DLX_PIPE_CTRL_PERF_EN
        dc_wait = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        #1;
        check("perf_stall_sat", 32'(perf_stall_cnt), 32'hFFFF);
`else
        dc_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end
        #1;
        check("perf_stall_off", 32'(perf_stall_cnt), 32'd0);
        check("perf_flush_off", 32'(perf_flush_cnt), 32'd0);
`endif
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
